// File: rtl/sfp_phy_link_supervisor.sv
// Per-channel SFP+ link supervisor: synchronises and debounces module status pins,
// sequences PHY reset against PLL lock and XCVR ready, retries with hold-off and locks out.
module sfp_phy_link_supervisor #(
  parameter int P_CHANNELS        = 1,
  parameter int P_DEBOUNCE_CYCLES = 1024,
  parameter int P_READY_TIMEOUT   = 65536,
  parameter int P_HOLDOFF_CYCLES  = 4096,
  parameter int P_RETRY_LIMIT     = 3
) (
  input  logic                                           i_clock,
  input  logic                                           i_reset,
  input  logic [P_CHANNELS-1:0]                          i_sfp_los,
  input  logic [P_CHANNELS-1:0]                          i_sfp_tx_fault,
  input  logic [P_CHANNELS-1:0]                          i_sfp_mod0_prsnt_n,
  input  logic                                           i_xcvr_pll_locked,
  input  logic [P_CHANNELS-1:0]                          i_phy_tx_ready,
  input  logic [P_CHANNELS-1:0]                          i_phy_rx_ready,
  input  logic [P_CHANNELS-1:0]                          i_fault_clear,
  output logic [P_CHANNELS-1:0]                          o_sfp_tx_disable,
  output logic [P_CHANNELS-1:0]                          o_phy_reset,
  output logic [P_CHANNELS-1:0]                          o_link_up,
  output logic [P_CHANNELS-1:0]                          o_fault_latched,
  output logic [P_CHANNELS*$clog2(P_RETRY_LIMIT+1)-1:0]  o_retry_count,
  output logic [P_CHANNELS*3-1:0]                        o_state
);
  localparam int RW = $clog2(P_RETRY_LIMIT + 1);
  localparam int DW = $clog2(P_DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(P_READY_TIMEOUT + P_HOLDOFF_CYCLES);
  localparam logic [DW-1:0] DEB_MAX      = DW'(P_DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] READY_LAST   = TW'(P_READY_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLDOFF_LAST = TW'(P_HOLDOFF_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(P_RETRY_LIMIT);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_PHY_WAIT = 3'd3,
    ST_LINK_UP  = 3'd4,
    ST_HOLDOFF  = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_t;

  for (genvar ch = 0; ch < P_CHANNELS; ch++) begin : g_ch
    logic [1:0]    los_sync, fault_sync, prsnt_sync;
    logic          los_s, fault_s, prsnt_n_s, good, deb_good;
    logic [DW-1:0] deb_cnt;
    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [RW-1:0] retry, retry_next;
    logic          ready_timeout, holdoff_done, both_ready, counting;
    logic          tx_disable_q, phy_reset_q, link_up_q, fault_q;
    logic [RW-1:0] retry_q;
    logic [2:0]    state_q;

    assign los_s         = los_sync[1];
    assign fault_s       = fault_sync[1];
    assign prsnt_n_s     = prsnt_sync[1];
    assign good          = ~(los_s | fault_s | prsnt_n_s);
    // Gated by good so qualification drops in the very cycle a pin goes bad.
    assign deb_good      = good & (deb_cnt == DEB_MAX);
    assign ready_timeout = (timer == READY_LAST);
    assign holdoff_done  = (timer == HOLDOFF_LAST);
    assign both_ready    = i_phy_tx_ready[ch] & i_phy_rx_ready[ch];
    assign counting      = (state == ST_PLL_WAIT) | (state == ST_PHY_WAIT) | (state == ST_HOLDOFF);

    // Synchronisers preset to "absent / faulted / no signal" so reset is always safe.
    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        los_sync   <= 2'b11;
        fault_sync <= 2'b11;
        prsnt_sync <= 2'b11;
        deb_cnt    <= '0;
      end else begin
        los_sync   <= {los_sync[0], i_sfp_los[ch]};
        fault_sync <= {fault_sync[0], i_sfp_tx_fault[ch]};
        prsnt_sync <= {prsnt_sync[0], i_sfp_mod0_prsnt_n[ch]};
        if (!good)
          deb_cnt <= '0;
        else if (deb_cnt != DEB_MAX)
          deb_cnt <= deb_cnt + DW'(1);
      end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        state <= ST_ABSENT;
        timer <= '0;
        retry <= '0;
      end else begin
        state <= state_next;
        timer <= timer_next;
        retry <= retry_next;
      end
    end

    always_comb begin
      state_next = state;
      retry_next = retry;
      if (prsnt_n_s && (state != ST_ABSENT)) begin
        state_next = ST_ABSENT;
        retry_next = '0;
      end else begin
        case (state)
          ST_ABSENT:   if (!prsnt_n_s) state_next = ST_QUALIFY;
          ST_QUALIFY:  if (deb_good) state_next = ST_PLL_WAIT;
          ST_PLL_WAIT: begin
            if (i_xcvr_pll_locked)  state_next = ST_PHY_WAIT;
            else if (ready_timeout) state_next = ST_HOLDOFF;
          end
          ST_PHY_WAIT: begin
            // Success is tested first so a ready arriving on the timeout cycle wins.
            if (both_ready)
              state_next = ST_LINK_UP;
            else if (!deb_good || !i_xcvr_pll_locked || ready_timeout)
              state_next = ST_HOLDOFF;
          end
          ST_LINK_UP: begin
            if (!deb_good || !i_xcvr_pll_locked || !both_ready) state_next = ST_HOLDOFF;
          end
          ST_HOLDOFF: begin
            if (holdoff_done) state_next = (retry < RETRY_MAX) ? ST_QUALIFY : ST_LOCKOUT;
          end
          ST_LOCKOUT: begin
            if (i_fault_clear[ch]) begin
              state_next = ST_ABSENT;
              retry_next = '0;
            end
          end
          default: state_next = ST_ABSENT;
        endcase
        if ((state_next == ST_HOLDOFF) && (state != ST_HOLDOFF) && (retry != RETRY_MAX))
          retry_next = retry + RW'(1);
        if ((state_next == ST_LINK_UP) && (state != ST_LINK_UP))
          retry_next = '0;
      end
      if (state_next != state)
        timer_next = '0;
      else if (counting)
        timer_next = timer + TW'(1);
      else
        timer_next = timer;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        tx_disable_q <= 1'b1;
        phy_reset_q  <= 1'b1;
        link_up_q    <= 1'b0;
        fault_q      <= 1'b0;
        retry_q      <= '0;
        state_q      <= 3'd0;
      end else begin
        tx_disable_q <= (state == ST_ABSENT) | (state == ST_HOLDOFF) | (state == ST_LOCKOUT);
        phy_reset_q  <= ~((state == ST_PHY_WAIT) | (state == ST_LINK_UP));
        link_up_q    <= (state == ST_LINK_UP);
        fault_q      <= (state == ST_LOCKOUT);
        retry_q      <= retry;
        state_q      <= state;
      end
    end

    assign o_sfp_tx_disable[ch]       = tx_disable_q;
    assign o_phy_reset[ch]            = phy_reset_q;
    assign o_link_up[ch]              = link_up_q;
    assign o_fault_latched[ch]        = fault_q;
    assign o_retry_count[ch*RW +: RW] = retry_q;
    assign o_state[ch*3 +: 3]         = state_q;
  end
endmodule

// File: tb/tb_sfp_phy_link_supervisor.sv
// Bench for sfp_phy_link_supervisor: directed scenarios with literal expectations, plus a
// cycle-level reference model of the supervisor rules compared on every falling edge.
module tb_sfp_phy_link_supervisor;
  localparam int CH = 2, DEB = 4, TO = 16, HO = 8, RL = 2, RW = 2;
  localparam int ABSENT = 0, QUALIFY = 1, PLL_WAIT = 2, PHY_WAIT = 3;
  localparam int LINK_UP = 4, HOLDOFF = 5, LOCKOUT = 6;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] los, fault, prsnt_n, tx_rdy, rx_rdy, clr;
  logic pll;
  logic [CH-1:0] tx_disable, phy_reset, link_up, fault_latched;
  logic [CH*RW-1:0] retry_count;
  logic [CH*3-1:0] state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int n;

  sfp_phy_link_supervisor #(
    .P_CHANNELS(CH), .P_DEBOUNCE_CYCLES(DEB), .P_READY_TIMEOUT(TO),
    .P_HOLDOFF_CYCLES(HO), .P_RETRY_LIMIT(RL)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_sfp_los(los), .i_sfp_tx_fault(fault), .i_sfp_mod0_prsnt_n(prsnt_n),
    .i_xcvr_pll_locked(pll), .i_phy_tx_ready(tx_rdy), .i_phy_rx_ready(rx_rdy),
    .i_fault_clear(clr),
    .o_sfp_tx_disable(tx_disable), .o_phy_reset(phy_reset), .o_link_up(link_up),
    .o_fault_latched(fault_latched), .o_retry_count(retry_count), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference model: phase, time spent in phase, failed attempts, good-run length, pin history
  int m_ph[CH], m_age[CH], m_tries[CH], m_run[CH];
  int v_ph[CH], v_tries[CH];
  logic [2:0] m_p1[CH], m_p2[CH];

  task automatic model_step(input int c);
    logic los_s, flt_s, abs_s, good, qual, rdy;
    int nph, ntries;
    los_s = m_p2[c][0];
    flt_s = m_p2[c][1];
    abs_s = m_p2[c][2];
    good = !(los_s || flt_s || abs_s);
    qual = good && (m_run[c] >= DEB);
    rdy = tx_rdy[c] && rx_rdy[c];
    nph = m_ph[c];
    ntries = m_tries[c];
    v_ph[c] = m_ph[c];
    v_tries[c] = m_tries[c];
    if (abs_s && m_ph[c] != ABSENT) begin
      nph = ABSENT;
      ntries = 0;
    end else begin
      case (m_ph[c])
        ABSENT:   if (!abs_s) nph = QUALIFY;
        QUALIFY:  if (qual) nph = PLL_WAIT;
        PLL_WAIT: if (pll) nph = PHY_WAIT; else if (m_age[c] + 1 == TO) nph = HOLDOFF;
        PHY_WAIT: if (rdy) nph = LINK_UP;
                  else if (!qual || !pll || m_age[c] + 1 == TO) nph = HOLDOFF;
        LINK_UP:  if (!qual || !pll || !rdy) nph = HOLDOFF;
        HOLDOFF:  if (m_age[c] + 1 == HO) nph = (m_tries[c] < RL) ? QUALIFY : LOCKOUT;
        LOCKOUT:  if (clr[c]) begin nph = ABSENT; ntries = 0; end
        default:  nph = ABSENT;
      endcase
      if (nph == HOLDOFF && m_ph[c] != HOLDOFF) ntries = (ntries < RL) ? ntries + 1 : RL;
      if (nph == LINK_UP && m_ph[c] != LINK_UP) ntries = 0;
    end
    m_age[c] = (nph == m_ph[c]) ? m_age[c] + 1 : 0;
    m_run[c] = good ? ((m_run[c] < DEB) ? m_run[c] + 1 : DEB) : 0;
    m_ph[c] = nph;
    m_tries[c] = ntries;
    m_p2[c] = m_p1[c];
    m_p1[c] = {prsnt_n[c], fault[c], los[c]};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_ph[c] = ABSENT; m_age[c] = 0; m_tries[c] = 0; m_run[c] = 0;
        v_ph[c] = ABSENT; v_tries[c] = 0;
        m_p1[c] = 3'b111; m_p2[c] = 3'b111;
      end
    end else begin
      for (int c = 0; c < CH; c++) model_step(c);
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("ch%0d_state", c), state[c*3 +: 3], v_ph[c]);
        check($sformatf("ch%0d_tx_disable", c), tx_disable[c],
              (v_ph[c] == ABSENT || v_ph[c] == HOLDOFF || v_ph[c] == LOCKOUT) ? 1 : 0);
        check($sformatf("ch%0d_phy_reset", c), phy_reset[c],
              (v_ph[c] == PHY_WAIT || v_ph[c] == LINK_UP) ? 0 : 1);
        check($sformatf("ch%0d_link_up", c), link_up[c], (v_ph[c] == LINK_UP) ? 1 : 0);
        check($sformatf("ch%0d_fault_latched", c), fault_latched[c], (v_ph[c] == LOCKOUT) ? 1 : 0);
        check($sformatf("ch%0d_retry_count", c), retry_count[c*RW +: RW], v_tries[c]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic int st(input int c);
    return int'(state[c*3 +: 3]);
  endfunction

  task automatic wait_for(input int c, input int target, input int lim, output int cnt);
    cnt = 0;
    while (st(c) != target && cnt < lim) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; los = '1; fault = '1; prsnt_n = '1;
    tx_rdy = '0; rx_rdy = '0; clr = '0; pll = 1'b1;
    tick(3);
    cmp_en = 1'b1;
    check("rst_state", state, 0);
    check("rst_tx_disable", tx_disable, 2'b11);
    check("rst_phy_reset", phy_reset, 2'b11);
    check("rst_link_up", link_up, 0);
    check("rst_fault", fault_latched, 0);
    check("rst_retry", retry_count, 0);
    rst = 1'b0;
    tick(2);

    // clean bring-up of ch0: pins change at cycle 0
    los[0] = 0; fault[0] = 0; prsnt_n[0] = 0;
    tick(3);
    check("up_txdis_c3", tx_disable[0], 1);
    tick(1);
    check("up_txdis_c4", tx_disable[0], 0);
    check("up_state_c4", st(0), QUALIFY);
    n = 4;
    while (phy_reset[0] && n < 30) begin tick(1); n++; end
    check("up_phy_reset_fall_cycle", n, 9);
    tick(5);
    tx_rdy[0] = 1; rx_rdy[0] = 1;
    tick(1);
    check("up_link_before", link_up[0], 0);
    tick(1);
    check("up_link_after", link_up[0], 1);
    check("up_retry", retry_count[1:0], 0);
    check("up_ch1_absent", st(1), ABSENT);
    check("up_ch1_txdis", tx_disable[1], 1);

    // fault_clear outside LOCKOUT has no effect
    clr[0] = 1; tick(1); clr[0] = 0;
    tick(2);
    check("clr_in_link_state", st(0), LINK_UP);
    check("clr_in_link_fault", fault_latched[0], 0);

    // link drop, then removal during HOLDOFF
    rx_rdy[0] = 0;
    tick(2);
    check("drop_state", st(0), HOLDOFF);
    check("drop_link", link_up[0], 0);
    check("drop_txdis", tx_disable[0], 1);
    check("drop_retry", retry_count[1:0], 1);
    prsnt_n[0] = 1;
    tick(3);
    check("remove_still_holdoff", st(0), HOLDOFF);
    tick(1);
    check("remove_absent", st(0), ABSENT);
    check("remove_retry", retry_count[1:0], 0);

    // glitchy LOS on ch0 while ch1 comes up cleanly
    prsnt_n = 2'b00; los[1] = 0; fault[1] = 0;
    tx_rdy[1] = 1; rx_rdy[1] = 1;
    for (int i = 0; i < 40; i++) begin
      los[0] = (i % 3 == 2);
      tick(1);
      if (i >= 3) begin
        check("glitch_state", st(0), QUALIFY);
        check("glitch_phy_reset", phy_reset[0], 1);
      end
    end

    // PLL never locks: two timed-out attempts then LOCKOUT
    los[0] = 0; pll = 0;
    wait_for(0, PLL_WAIT, 30, n);
    check("nolock_enter_pll_wait", st(0), PLL_WAIT);
    wait_for(0, HOLDOFF, 40, n);
    check("nolock_pll_wait_len1", n, 16);
    check("nolock_retry1", retry_count[1:0], 1);
    wait_for(0, QUALIFY, 20, n);
    check("nolock_holdoff_len1", n, 8);
    wait_for(0, PLL_WAIT, 20, n);
    check("nolock_requalify", n, 1);
    wait_for(0, HOLDOFF, 40, n);
    check("nolock_pll_wait_len2", n, 16);
    check("nolock_retry2", retry_count[1:0], 2);
    wait_for(0, LOCKOUT, 20, n);
    check("nolock_holdoff_len2", n, 8);
    check("lockout_fault", fault_latched[0], 1);
    check("lockout_retry", retry_count[1:0], 2);
    check("lockout_phy_reset", phy_reset[0], 1);

    // lockout release
    tick(3);
    check("lockout_held", st(0), LOCKOUT);
    clr[0] = 1; tick(1); clr[0] = 0;
    check("release_lag", st(0), LOCKOUT);
    tick(1);
    check("release_absent", st(0), ABSENT);
    check("release_retry", retry_count[1:0], 0);
    check("release_fault", fault_latched[0], 0);
    tick(1);
    check("release_qualify", st(0), QUALIFY);

    // asynchronous reset with ch0 in LINK_UP
    pll = 1; tx_rdy[0] = 1; rx_rdy[0] = 1;
    wait_for(0, LINK_UP, 40, n);
    check("ar_link_up", link_up[0], 1);
    #2 rst = 1'b1;
    #1;
    check("ar_state", state, 0);
    check("ar_tx_disable", tx_disable, 2'b11);
    check("ar_phy_reset", phy_reset, 2'b11);
    check("ar_link_up_low", link_up, 0);
    check("ar_fault", fault_latched, 0);
    check("ar_retry", retry_count, 0);
    tick(2);
    rst = 1'b0;
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
